ifetch_prefetch: RTL and testbench
==================================

IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 Parameter PC_WIDTH, default 10: byte-address PC width.
REQ-002 Parameter IMEM_DEPTH, default 64: instruction words, power of two.
REQ-003 Parameter QUEUE_DEPTH, default 4: prefetch queue entries, power of two, >=2.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ip_redirect  input  1  taken branch/jump: flush and refetch.
REQ-007 ip_redirect_pc  input  PC_WIDTH  redirect target; bits [1:0] ignored, treated as 0.
REQ-008 ip_ready  input  1  decode accepts the head instruction this cycle.
REQ-009 ip_imem_we / ip_imem_waddr / ip_imem_wdata  input  1 / log2(IMEM_DEPTH) / 32  program-load write port.
REQ-010 op_valid  output  1  head entry holds a valid instruction.
REQ-011 op_instruction / op_PC / op_PC_plus_4  output  32 / PC_WIDTH / PC_WIDTH  head instruction, its PC, PC+4.
REQ-012 op_flush_count  output  16  redirect counter (see Configuration).

Function
REQ-013 Instruction memory: synchronous read; read issued at edge E is pushed into queue at edge E+1.
REQ-014 Word address = PC[PC_WIDTH-1:2] modulo IMEM_DEPTH; fetch PC increments by 4, wraps modulo 2^PC_WIDTH.
REQ-015 Issue condition at an edge: ip_redirect=1, or (queue count + in-flight reads) < QUEUE_DEPTH; pop in same cycle not credited.
REQ-016 Issue address: ip_redirect_pc when ip_redirect=1, else fetch PC; fetch PC becomes issued address + 4.
REQ-017 Head outputs combinational from queue head; op_PC_plus_4 = op_PC + 4 modulo 2^PC_WIDTH.
REQ-018 Pop when op_valid && ip_ready; entry content held stable while op_valid && !ip_ready.
REQ-019 Simultaneous push and pop: count unchanged, order preserved.
REQ-020 Redirect edge N: queue emptied, read issued at N-1 discarded (not pushed at N), target read issued at N; op_valid=1 with target after edge N+1.
REQ-021 Redirect wins over simultaneous pop/push; back-to-back redirects: only the latest target survives.
REQ-022 Sustained throughput: one instruction per cycle while ip_ready=1 and no redirect.
REQ-023 op_valid=0 => op_instruction, op_PC, op_PC_plus_4 driven 0.
REQ-024 Memory write takes effect for reads issued after the write edge; same-edge read/write of one address returns old data.
REQ-025 Memory contents initialised to zero at elaboration; not cleared by reset.

Reset
REQ-026 reset=0 immediately clears queue pointers/count, in-flight flag, fetch PC (=0), op_valid, op_flush_count.
REQ-027 Reset mid-operation discards all queued and in-flight instructions; first edge after release issues PC 0; op_valid=1 after second edge.

Configuration
REQ-028 Macro IFETCH_PERF_CNT_EN defined: op_flush_count increments by 1 per edge with ip_redirect=1, saturates at 0xFFFF.
REQ-029 Macro IFETCH_PERF_CNT_EN undefined: no counter logic; op_flush_count tied to 0.

Verification
REQ-030 Load words 0..7 = 0x11..0x18, release reset, ip_ready=1 -> op_valid after edge 2; instructions 0x11,0x12,... on consecutive cycles, op_PC 0,4,8,...
REQ-031 ip_ready=0 for 10 cycles, depth 4 -> queue holds 4 entries, no further issue, head stays 0x11/PC 0; ip_ready=1 -> 0x11..0x14 back-to-back, no gap.
REQ-032 ip_redirect=1, ip_redirect_pc=0x01B at edge N while queue non-empty -> op_valid=0 after N, word 6 with op_PC=0x018 after N+1, stale words never appear.
REQ-033 Fetch from PC 0x3FC (PC_WIDTH 10, IMEM_DEPTH 64) -> PC 0x3FC returns word 63 (0x3FC>>2 mod 64), next op_PC 0x000, op_PC_plus_4 of 0x3FC is 0x000.
REQ-034 Assert reset=0 mid-stream between edges -> op_valid=0 immediately; release -> stream restarts at PC 0.
REQ-035 With IFETCH_PERF_CNT_EN: 3 redirects -> op_flush_count=3; without: stays 0.

Source files
------------

// File: rtl/ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch
//
// Instruction fetch unit with a small prefetch queue in front of a
// synchronous-read instruction memory. A read issued at one edge delivers
// its word into the queue at the next edge. Decode consumes from the queue
// head with a valid/ready handshake, and a taken branch flushes the queue.
//
// Optional feature: define IFETCH_PERF_CNT_EN to build a saturating 16-bit
// redirect counter on op_flush_count. Without it the output is tied to 0.
//
// Parameters
//   PC_WIDTH     byte-address PC width
//   IMEM_DEPTH   instruction words (power of two)
//   QUEUE_DEPTH  prefetch queue entries (power of two, >= 2)
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous active-low reset
//   ip_redirect      taken branch/jump: flush the queue and refetch
//   ip_redirect_pc   redirect target (bits [1:0] ignored)
//   ip_ready         decode accepts the head instruction this cycle
//   ip_imem_we       program-load write enable
//   ip_imem_waddr    program-load word address
//   ip_imem_wdata    program-load data
//   op_valid         queue head holds a valid instruction
//   op_instruction   head instruction (0 when not valid)
//   op_PC            head PC (0 when not valid)
//   op_PC_plus_4     head PC + 4 (0 when not valid)
//   op_flush_count   redirect counter (0 unless IFETCH_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module ifetch_prefetch #(
    parameter int PC_WIDTH    = 10,
    parameter int IMEM_DEPTH  = 64,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ip_redirect,
    input  logic [PC_WIDTH-1:0]           ip_redirect_pc,
    input  logic                          ip_ready,
    input  logic                          ip_imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] ip_imem_waddr,
    input  logic [31:0]                   ip_imem_wdata,
    output logic                          op_valid,
    output logic [31:0]                   op_instruction,
    output logic [PC_WIDTH-1:0]           op_PC,
    output logic [PC_WIDTH-1:0]           op_PC_plus_4,
    output logic [15:0]                   op_flush_count
);

    localparam int AW    = $clog2(IMEM_DEPTH);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Program memory: zero at elaboration, untouched by reset.
    logic [31:0] imem [IMEM_DEPTH] = '{default: '0};

    // Fetch state
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] issue_pc;
    logic [AW-1:0]       issue_word;
    logic                issue;
    logic                rd_pending;   // a read issued last edge lands this edge
    logic [31:0]         rd_data;
    logic [PC_WIDTH-1:0] rd_pc;

    // Prefetch queue
    logic [31:0]         q_instr [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      occupancy;
    logic                push;
    logic                pop;

    // Bits [1:0] of the redirect target are forced to zero and never read.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^ip_redirect_pc[1:0];

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        issue_pc  = fetch_pc;
        if (ip_redirect) begin
            issue_pc = {ip_redirect_pc[PC_WIDTH-1:2], 2'b00};
        end
        issue_word = AW'(issue_pc >> 2);

        // Credit check counts reads still in flight; a pop in the same cycle
        // does not free a slot until the next edge.
        occupancy = {1'b0, count} + (CNT_W+1)'(rd_pending);
        issue     = ip_redirect || (occupancy < (CNT_W+1)'(QUEUE_DEPTH));

        // A redirect discards the landing read and overrides any pop.
        push = rd_pending && !ip_redirect;
        pop  = (count != '0) && ip_ready && !ip_redirect;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc   <= '0;
            rd_pending <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                fetch_pc <= issue_pc + PC_WIDTH'(4);
            end
            if (ip_redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: memory arrays and data payloads carry no reset; validity is
    // tracked solely by the reset control state above.
    always_ff @(posedge clock) begin
        if (ip_imem_we) begin
            imem[ip_imem_waddr] <= ip_imem_wdata;
        end
    end

    // Synchronous read; a same-edge write to the same word returns old data.
    always_ff @(posedge clock) begin
        if (issue) begin
            rd_data <= imem[issue_word];
            rd_pc   <= issue_pc;
        end
        if (push) begin
            q_instr[tail] <= rd_data;
            q_pc[tail]    <= rd_pc;
        end
    end

    // Head outputs, forced to zero while the queue is empty.
    always_comb begin
        op_valid       = (count != '0);
        op_instruction = '0;
        op_PC          = '0;
        op_PC_plus_4   = '0;
        if (op_valid) begin
            op_instruction = q_instr[head];
            op_PC          = q_pc[head];
            op_PC_plus_4   = q_pc[head] + PC_WIDTH'(4);
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] flush_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_count <= '0;
        end else if (ip_redirect && (flush_count != 16'hFFFF)) begin
            flush_count <= flush_count + 16'd1;
        end
    end

    assign op_flush_count = flush_count;
`else
    assign op_flush_count = '0;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch_prefetch
//
// Drives ifetch_prefetch with directed scenarios followed by random traffic,
// comparing every cycle against a queue-based reference model of the fetch
// unit (memory array, instruction queue, list of reads in flight).
// ---------------------------------------------------------------------------
module tb_ifetch_prefetch;

    localparam int PW = 10;
    localparam int MD = 64;
    localparam int QD = 4;

    logic          clock;
    logic          reset;
    logic          ip_redirect;
    logic [PW-1:0] ip_redirect_pc;
    logic          ip_ready;
    logic          ip_imem_we;
    logic [5:0]    ip_imem_waddr;
    logic [31:0]   ip_imem_wdata;
    logic          op_valid;
    logic [31:0]   op_instruction;
    logic [PW-1:0] op_PC;
    logic [PW-1:0] op_PC_plus_4;
    logic [15:0]   op_flush_count;

    ifetch_prefetch #(.PC_WIDTH(PW), .IMEM_DEPTH(MD), .QUEUE_DEPTH(QD)) dut (
        .clock          (clock),
        .reset          (reset),
        .ip_redirect    (ip_redirect),
        .ip_redirect_pc (ip_redirect_pc),
        .ip_ready       (ip_ready),
        .ip_imem_we     (ip_imem_we),
        .ip_imem_waddr  (ip_imem_waddr),
        .ip_imem_wdata  (ip_imem_wdata),
        .op_valid       (op_valid),
        .op_instruction (op_instruction),
        .op_PC          (op_PC),
        .op_PC_plus_4   (op_PC_plus_4),
        .op_flush_count (op_flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        int          pc;
    } ent_t;

    logic [31:0] m_mem [MD];
    ent_t        m_q[$];     // instructions visible to decode, head first
    ent_t        m_pend[$];  // reads issued, arriving next edge
    int          m_fpc;
    int          m_flush;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend.delete();
        m_fpc   = 0;
        m_flush = 0;
    endtask

    // One rising edge of the reference, using the inputs currently driven.
    task automatic model_edge();
        bit   iss;
        int   a;
        ent_t e;
        if (reset) begin
            iss = ip_redirect || ((m_q.size() + m_pend.size()) < QD);
            if (ip_redirect) begin
                m_q.delete();
                m_pend.delete();
            end else begin
                if (m_q.size() > 0 && ip_ready) void'(m_q.pop_front());
                if (m_pend.size() > 0) m_q.push_back(m_pend.pop_front());
            end
            if (iss) begin
                a = ip_redirect ? (int'(ip_redirect_pc) / 4) * 4 : m_fpc;
                e.pc    = a;
                e.instr = m_mem[(a / 4) % MD];  // read sees pre-write contents
                m_pend.push_back(e);
                m_fpc = (a + 4) % (1 << PW);
            end
`ifdef IFETCH_PERF_CNT_EN
            if (ip_redirect && m_flush < 65535) m_flush++;
`endif
        end
        if (ip_imem_we) m_mem[ip_imem_waddr] = ip_imem_wdata;
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] e_instr;
        int          e_pc;
        int          e_pc4;
        bit          e_valid;
        e_valid = (m_q.size() > 0);
        e_instr = e_valid ? m_q[0].instr : 32'h0;
        e_pc    = e_valid ? m_q[0].pc : 0;
        e_pc4   = e_valid ? (m_q[0].pc + 4) % (1 << PW) : 0;
        check({tag, ".valid"}, 32'(op_valid), 32'(e_valid));
        check({tag, ".instr"}, op_instruction, e_instr);
        check({tag, ".pc"},    32'(op_PC), 32'(e_pc));
        check({tag, ".pc4"},   32'(op_PC_plus_4), 32'(e_pc4));
        check({tag, ".flush"}, 32'(op_flush_count), 32'(m_flush));
    endtask

    // Clock one edge, advance the model, compare #1 after the edge.
    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_valid"}, 32'(op_valid), 32'h0);
        compare_all({tag, ".rst"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < MD; i++) m_mem[i] = 32'h0;
        model_reset();
        reset          = 1'b0;
        ip_redirect    = 1'b0;
        ip_redirect_pc = '0;
        ip_ready       = 1'b0;
        ip_imem_we     = 1'b0;
        ip_imem_waddr  = '0;
        ip_imem_wdata  = '0;

        // Reset state
        #1;
        compare_all("reset_state");

        // Program load under reset: words 0..7 = 0x11..0x18, word 63 marker
        for (int i = 0; i < 9; i++) begin
            ip_imem_we    = 1'b1;
            ip_imem_waddr = (i < 8) ? 6'(i) : 6'd63;
            ip_imem_wdata = (i < 8) ? 32'h11 + 32'(i) : 32'hDEAD003F;
            step("load");
        end
        ip_imem_we = 1'b0;

        // First fetch after release: valid only after the second edge
        reset    = 1'b1;
        ip_ready = 1'b1;
        step("boot1");
        check("boot1_valid", 32'(op_valid), 32'h0);
        step("boot2");
        check("boot2_valid", 32'(op_valid), 32'h1);
        check("boot2_instr", op_instruction, 32'h11);
        check("boot2_pc", 32'(op_PC), 32'h0);
        for (int i = 1; i < 4; i++) begin
            step("stream");
            check("stream_instr", op_instruction, 32'h11 + 32'(i));
            check("stream_pc", 32'(op_PC), 32'(4 * i));
        end

        // Reset between edges mid-stream, then release between edges
        reset_pulse("midreset");
        #2;
        reset    = 1'b1;
        ip_ready = 1'b0;

        // Stall: queue fills to depth, head stays at PC 0
        for (int i = 0; i < 10; i++) step("stall");
        check("stall_valid", 32'(op_valid), 32'h1);
        check("stall_instr", op_instruction, 32'h11);
        check("stall_pc", 32'(op_PC), 32'h0);
        ip_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step("drain");
            check("drain_valid", 32'(op_valid), 32'h1);
            check("drain_instr", op_instruction, 32'h11 + 32'(i));
        end

        // Redirect to unaligned 0x01B while the queue holds entries
        ip_ready       = 1'b0;
        ip_redirect    = 1'b1;
        ip_redirect_pc = 10'h01B;
        step("redir");
        check("redir_valid", 32'(op_valid), 32'h0);
        ip_redirect = 1'b0;
        ip_ready    = 1'b1;
        step("redir1");
        check("redir1_instr", op_instruction, 32'h17);
        check("redir1_pc", 32'(op_PC), 32'h018);
        step("redir2");
        check("redir2_instr", op_instruction, 32'h18);
        check("redir2_pc", 32'(op_PC), 32'h01C);

        // PC wrap: 0x3FC reads word 63, then wraps to PC 0
        ip_redirect    = 1'b1;
        ip_redirect_pc = 10'h3FC;
        step("wrap");
        ip_redirect = 1'b0;
        step("wrap1");
        check("wrap1_instr", op_instruction, 32'hDEAD003F);
        check("wrap1_pc", 32'(op_PC), 32'h3FC);
        check("wrap1_pc4", 32'(op_PC_plus_4), 32'h000);
        step("wrap2");
        check("wrap2_instr", op_instruction, 32'h11);
        check("wrap2_pc", 32'(op_PC), 32'h000);

        // Third redirect since the last reset
        ip_redirect    = 1'b1;
        ip_redirect_pc = 10'h000;
        step("redir3");
        ip_redirect = 1'b0;
        step("redir3b");
`ifdef IFETCH_PERF_CNT_EN
        check("flush_count3", 32'(op_flush_count), 32'd3);
`else
        check("flush_count0", 32'(op_flush_count), 32'd0);
`endif

        // Random traffic: redirects, stalls, program writes, rare resets
        for (int c = 0; c < 600; c++) begin
            ip_redirect    = ($urandom % 8) == 0;
            ip_redirect_pc = PW'($urandom);
            ip_ready       = ($urandom % 4) != 0;
            ip_imem_we     = ($urandom % 6) == 0;
            ip_imem_waddr  = 6'($urandom);
            ip_imem_wdata  = $urandom;
            if (($urandom % 150) == 0) begin
                reset_pulse("rand");
                step("rand_inreset");
                reset = 1'b1;
            end
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
